// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and framing constants for the UART command endpoint
package uart_pkg;
  typedef enum logic {RX_IDLE, RECV} rx_state_t;
  typedef enum logic {TX_IDLE, XMIT} tx_state_t;
  typedef enum logic {HIGH, LOW} wrap_state_t;
  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam int BITS_PER_FRAME = 10;
endpackage

// File: rtl/uart_wrapper_if.sv
// uart_wrapper_if: command/response handshake between the serial endpoint and the command processor
interface uart_wrapper_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;
  modport master(input cmd, cmd_rdy, tx_done, output clr_cmd_rdy, trmt, resp);
  modport slave(output cmd, cmd_rdy, tx_done, input clr_cmd_rdy, trmt, resp);
endinterface

// File: rtl/uart.sv
// uart: 8N1 byte transceiver; receiver samples at bit centres, transmitter shifts a 9-bit register
module uart
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [3:0] LAST = 4'(BITS_PER_FRAME - 1);
  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic rx_ff1, rx_s, rx_q, rx_tick, tx_tick, tx_last;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [3:0] rx_bits, tx_bits;
  logic [8:0] tx_shift;
  assign rx_tick = rx_cnt == CW'(1);
  assign tx_tick = tx_cnt == CW'(1);
  assign TX = tx_state == XMIT ? tx_shift[0] : 1'b1;
  always_comb begin
    rx_rdy = rx_state == RECV && rx_tick && rx_bits == LAST;
    rx_next = rx_state == RX_IDLE ? (rx_q && !rx_s ? RECV : RX_IDLE) : (rx_rdy ? RX_IDLE : RECV);
    tx_last = tx_state == XMIT && tx_tick && tx_bits == LAST;
    tx_next = tx_state == TX_IDLE ? (trmt ? XMIT : TX_IDLE) : (tx_last ? TX_IDLE : XMIT);
  end
  // rx_q delays the synchronized line once more so a falling edge can be seen
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {rx_ff1, rx_s, rx_q} <= 3'b111;
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_bits <= '0;
      rx_data <= '0;
    end else begin
      {rx_ff1, rx_s, rx_q} <= {RX, rx_ff1, rx_s};
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) begin
        rx_cnt <= HALF;
        rx_bits <= '0;
      end else if (rx_tick) begin
        rx_cnt <= FULL;
        rx_bits <= rx_bits + 4'd1;
        if (rx_bits != LAST) rx_data <= {rx_s, rx_data[7:1]};
      end else rx_cnt <= rx_cnt - CW'(1);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_bits <= '0;
      tx_shift <= '1;
      tx_done <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE) begin
        if (trmt) begin
          tx_shift <= {tx_data, 1'b0};
          tx_cnt <= FULL;
          tx_bits <= '0;
          tx_done <= 1'b0;
        end
      end else if (tx_tick) begin
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_cnt <= FULL;
        tx_bits <= tx_bits + 4'd1;
        if (tx_last) tx_done <= 1'b1;
      end else tx_cnt <= tx_cnt - CW'(1);
    end
endmodule

// File: rtl/uart_wrapper.sv
// uart_wrapper: assembles two received bytes (high first) into a 16-bit command; forwards responses to the transmitter
module uart_wrapper
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic RX,
  output logic TX,
  uart_wrapper_if.slave bus
);
  wrap_state_t state, state_next;
  logic [7:0] rx_data, high_byte;
  logic rx_rdy;
  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .rx_data(rx_data), .rx_rdy(rx_rdy),
    .tx_data(bus.resp), .trmt(bus.trmt), .tx_done(bus.tx_done)
  );
  always_comb state_next = rx_rdy ? (state == HIGH ? LOW : HIGH) : state;
  // a completing low byte beats a same-cycle clear; a new high byte supersedes any pending command
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HIGH;
      high_byte <= '0;
      bus.cmd <= '0;
      bus.cmd_rdy <= 1'b0;
    end else begin
      state <= state_next;
      if (rx_rdy && state == HIGH) high_byte <= rx_data;
      if (rx_rdy && state == LOW) bus.cmd <= {high_byte, rx_data};
      bus.cmd_rdy <= rx_rdy ? state == LOW : bus.cmd_rdy && !bus.clr_cmd_rdy;
    end
endmodule

// File: tb/tb_uart_wrapper.sv
// tb_uart_wrapper: table-driven and randomized checks of command assembly and response serialization
module tb_uart_wrapper;
  localparam int D = 16;
  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp;
    logic        clr_after;
    logic        same_clr;
  } vec_t;
  logic clk = 0, rst_n = 0, RX = 1;
  logic TX;
  int checks = 0, errors = 0;
  uart_wrapper_if bus();
  uart_wrapper #(.BAUD_DIV(D)) dut (.clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask
  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bits(input logic [7:0] b, input int nbits);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      RX = f[i];
      tick(D);
    end
    RX = 1'b1;
  endtask
  task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp,
                          input logic clr_after, input logic same_clr);
    send_bits(hi, 10);
    chk1("rdy_after_high", bus.cmd_rdy, 1'b0);
    send_bits(lo, 9);
    tick(6);
    chk1("rdy_before_stop", bus.cmd_rdy, 1'b0);
    if (same_clr) begin
      bus.clr_cmd_rdy = 1'b1;
      for (int k = 0; k < 16 && !bus.cmd_rdy; k++) tick();
      bus.clr_cmd_rdy = 1'b0;
      chk1("rdy_set_wins", bus.cmd_rdy, 1'b1);
      tick();
      chk1("rdy_held", bus.cmd_rdy, 1'b1);
      tick(8);
    end else begin
      tick(10);
      chk1("rdy_after_low", bus.cmd_rdy, 1'b1);
    end
    chk16("cmd", bus.cmd, exp);
    if (clr_after) begin
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.clr_cmd_rdy = 1'b0;
      chk1("rdy_cleared", bus.cmd_rdy, 1'b0);
      chk16("cmd_kept", bus.cmd, exp);
    end
  endtask
  task automatic tx_check(input logic [7:0] r, input logic poke);
    logic [9:0] f;
    f = {1'b1, r, 1'b0};
    bus.resp = r;
    bus.trmt = 1'b1;
    tick();
    bus.trmt = 1'b0;
    chk1("tx_done_cleared", bus.tx_done, 1'b0);
    for (int c = 0; c < 10 * D; c++) begin
      if (c % D == 0 || c % D == D - 1) chk1($sformatf("tx_bit%0d_c%0d", c / D, c), TX, f[c / D]);
      if (c == 10 * D - 1) chk1("tx_done_early", bus.tx_done, 1'b0);
      bus.trmt = poke && c == 5 * D;
      bus.resp = (poke && c == 5 * D) ? 8'h3C : r;
      tick();
    end
    chk1("tx_done_set", bus.tx_done, 1'b1);
    chk1("tx_idle", TX, 1'b1);
    tick(3);
    chk1("tx_done_held", bus.tx_done, 1'b1);
  endtask
  initial begin
    vec_t tbl [5];
    logic [7:0] hi, lo;
    tbl = '{'{8'h4B, 8'hF4, 16'h4BF4, 1'b1, 1'b0},
            '{8'h2A, 8'h11, 16'h2A11, 1'b0, 1'b0},
            '{8'h00, 8'h00, 16'h0000, 1'b0, 1'b0},
            '{8'hFF, 8'hFF, 16'hFFFF, 1'b0, 1'b1},
            '{8'h80, 8'h01, 16'h8001, 1'b1, 1'b0}};
    bus.clr_cmd_rdy = 1'b0;
    bus.trmt = 1'b0;
    bus.resp = 8'h00;
    tick(2);
    chk1("reset_tx", TX, 1'b1);
    chk16("reset_cmd", bus.cmd, 16'h0000);
    chk1("reset_rdy", bus.cmd_rdy, 1'b0);
    chk1("reset_done", bus.tx_done, 1'b0);
    rst_n = 1'b1;
    tick(4);
    foreach (tbl[i]) send_cmd(tbl[i].hi, tbl[i].lo, tbl[i].exp, tbl[i].clr_after, tbl[i].same_clr);
    tx_check(8'hA5, 1'b1);
    for (int n = 0; n < 8; n++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      send_cmd(hi, lo, {hi, lo}, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int n = 0; n < 3; n++) tx_check(8'($urandom), 1'b0);
    fork
      send_cmd(8'h4B, 8'hF4, 16'h4BF4, 1'b0, 1'b0);
      tx_check(8'hA5, 1'b0);
    join
    chk1("rdy_pending", bus.cmd_rdy, 1'b1);
    bus.resp = 8'hA5;
    bus.trmt = 1'b1;
    tick();
    bus.trmt = 1'b0;
    send_bits(8'h55, 4);
    chk1("tx_mid_frame", TX, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("abort_tx", TX, 1'b1);
    chk1("abort_rdy", bus.cmd_rdy, 1'b0);
    chk16("abort_cmd", bus.cmd, 16'h0000);
    chk1("abort_done", bus.tx_done, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    send_cmd(8'h12, 8'h34, 16'h1234, 1'b1, 1'b0);
    send_bits(8'h77, 10);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    send_cmd(8'h56, 8'h78, 16'h5678, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_wrapper.md
# uart_wrapper

Command/response serial endpoint on the Knight side of the Bluetooth/UART link. It receives two 8N1 bytes from the remote host, high byte first, and assembles them into one 16-bit command for the command processor. It also serializes single response bytes (positive acknowledge, etc.) back to the host. It sits between the `RX`/`TX` pins of `KnightsTour` and the command-processing FSM.

## Interface
Parameters:
- `BAUD_DIV`, default 2604: clocks per bit (50 MHz / 19200 baud).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous reset, active low
- `RX`  in  1  serial input from host, idle high; asynchronous to `clk`
- `TX`  out  1  serial output to host, idle high
- `cmd`  out  16  assembled command `{high_byte, low_byte}`
- `cmd_rdy`  out  1  a complete command is held in `cmd`
- `clr_cmd_rdy`  in  1  consumer acknowledges `cmd`; clears `cmd_rdy`
- `trmt`  in  1  one-cycle strobe to start transmitting `resp`
- `resp`  in  8  response byte, sampled on the `trmt` cycle
- `tx_done`  out  1  last transmission finished; held until the next `trmt`

## Operation
Receiver:
- `RX` passes through a 2-flop synchronizer. Both flops reset to 1.
- IDLE → RECV on a synchronized falling edge.
- The baud counter first loads `BAUD_DIV/2`, then reloads `BAUD_DIV`.
- 10 samples are taken at bit centres: start, 8 data bits LSB first, stop.
- After the stop-bit sample the byte is complete: a one-cycle internal `rx_rdy` strobe fires and the receiver returns to IDLE.
- There is no framing check. The stop-bit value is ignored.

Wrapper FSM:
- States: HIGH (awaiting the high byte) and LOW (awaiting the low byte).
- HIGH + `rx_rdy`: latch the byte into `high_byte`, clear `cmd_rdy`, go to LOW.
- LOW + `rx_rdy`: `cmd <= {high_byte, rx_data}`, set `cmd_rdy`, go to HIGH.
- `clr_cmd_rdy` clears `cmd_rdy`. `cmd` keeps its value.
- If `clr_cmd_rdy` and the LOW-state `rx_rdy` occur in the same cycle, the set wins: `cmd_rdy` = 1.
- A new high byte arriving while `cmd_rdy` = 1 clears `cmd_rdy`, because the old command is superseded.

Transmitter:
- States: IDLE and XMIT.
- `trmt` in IDLE:
  - loads the 9-bit shift register `{resp, 0}`;
  - clears `tx_done`;
  - goes to XMIT.
- Each bit lasts `BAUD_DIV` clocks. The shift fills with 1s, so the stop bit is 1.
- After 10 bit periods the transmitter sets `tx_done` and returns to IDLE.
- `trmt` during XMIT is ignored.
- `TX` is the LSB of the shift register in XMIT and 1 in IDLE.

## Timing
Reset values:
- `TX` = 1, `cmd` = 0, `cmd_rdy` = 0, `tx_done` = 0.
- Both FSMs reset to IDLE/HIGH and both counters to 0.

Receive latency:
- `cmd_rdy` rises 1 clock after the stop-bit centre of the low byte.
- The stop-bit centre falls about 9.5·`BAUD_DIV` clocks after the start-edge detect, plus 2 clocks of synchronizer delay.

Transmit latency:
- `TX` falls 1 clock after `trmt`.
- `tx_done` rises exactly 10·`BAUD_DIV` clocks after `TX` falls.

Reset and boundary behaviour:
- Reset mid-byte aborts both directions immediately. `TX` = 1, and a partial RX byte or a pending high byte is discarded.
- RX and TX operate fully independently (full duplex).
- Counters are wide enough for `BAUD_DIV` (12 bits at the default; derive the width with `$clog2`).
- The bit counter is 4 bits and counts 0–9.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` {IDLE, RECV};
  - `tx_state_t` {IDLE, XMIT};
  - `wrap_state_t` {HIGH, LOW};
  - `BAUD_DIV_DEFAULT` = 2604;
  - `BITS_PER_FRAME` = 10.
- Sub-module `uart` (byte-level transceiver: `rx_data`, `rx_rdy`, `tx_data`, `trmt`, `tx_done`), instantiated once.
- `uart_wrapper` adds the HIGH/LOW assembly FSM and the `cmd`/`cmd_rdy` registers.

## Test plan
- Use `BAUD_DIV` = 16. Drive bytes 0x4B then 0xF4 on `RX` → `cmd` = 0x4BF4, `cmd_rdy` = 1 one clock after the second stop-bit sample; `cmd_rdy` = 0 before that.
- With `cmd_rdy` = 1, pulse `clr_cmd_rdy` → `cmd_rdy` = 0 on the next clock and `cmd` still 0x4BF4. Then send 0x2A, 0x11 → `cmd` = 0x2A11.
- `trmt` with `resp` = 0xA5 → `TX` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 16 clocks. `tx_done` = 1 at clock 160 after `TX` falls, then idle high. A second `trmt` mid-frame causes no change.
- Assert `clr_cmd_rdy` on the same cycle the low byte completes → `cmd_rdy` = 1.
- Assert `rst_n` low during the high byte's data bits → `TX` = 1 and `cmd_rdy` = 0 immediately. After release, a clean 0x12, 0x34 → `cmd` = 0x1234 (no stale high byte).
- Transmit 0xA5 while simultaneously receiving 0x4B, 0xF4 → both complete correctly.
